// File: rtl/risc_pkg.sv
// Shared RV32I definitions: opcodes, decode bundle, immediate formats.
// Imported by the decode lane and the decode stage.
package risc_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [6:0] FUNCT7_ALT = 7'h20;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [2:0]         funct3;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [6:0]         funct7;
    logic               r;
    logic               i;
    logic               s;
    logic               b;
    logic               u;
    logic               j;
    logic               is_load;
    logic               is_store;
    logic               is_branch;
    logic               is_jal;
    logic               is_jalr;
    logic               is_lui;
    logic               is_auipc;
    logic               is_system;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               writes_rd;
    logic [RV_XLEN-1:0] imm;
  } dec_lane_t;

endpackage

// File: rtl/decode_lane.sv
// Combinational single-instruction RV32I decoder.
// Ports: instr/en in; dec (fields, flags, imm) and illegal out.
import risc_pkg::*;

module decode_lane #(
  parameter int XLEN = 32
) (
  input  logic [31:0] instr,
  input  logic        en,
  output dec_lane_t   dec,
  output logic        illegal
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       ill;
  imm_fmt_e   fmt;
  dec_lane_t  base;
  dec_lane_t  full;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]    imm_x;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  always_comb begin
    base        = '0;
    base.opcode = op;
    base.rd     = instr[11:7];
    base.funct3 = f3;
    base.rs1    = instr[19:15];
    base.rs2    = instr[24:20];
    base.funct7 = f7;
    full        = base;
    ill         = 1'b0;
    fmt         = IMM_NONE;
    unique case (1'b1)
      (op == OPC_OP): begin
        full.r         = 1'b1;
        full.uses_rs1  = 1'b1;
        full.uses_rs2  = 1'b1;
        full.writes_rd = 1'b1;
        if (f7 != 7'h00 && f7 != FUNCT7_ALT)
          ill = 1'b1;
        if (f7 == FUNCT7_ALT && f3 != 3'b000 && f3 != 3'b101)
          ill = 1'b1;
      end
      (op == OPC_OPIMM): begin
        full.i         = 1'b1;
        full.uses_rs1  = 1'b1;
        full.writes_rd = 1'b1;
        fmt            = IMM_I;
        if (f3 == 3'b001 || f3 == 3'b101)
          if (!(f7 == 7'h00 || (f7 == FUNCT7_ALT && f3 == 3'b101)))
            ill = 1'b1;
      end
      (op == OPC_LOAD): begin
        full.i         = 1'b1;
        full.is_load   = 1'b1;
        full.uses_rs1  = 1'b1;
        full.writes_rd = 1'b1;
        fmt            = IMM_I;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
          ill = 1'b1;
      end
      (op == OPC_STORE): begin
        full.s        = 1'b1;
        full.is_store = 1'b1;
        full.uses_rs1 = 1'b1;
        full.uses_rs2 = 1'b1;
        fmt           = IMM_S;
        if (f3 > 3'b010)
          ill = 1'b1;
      end
      (op == OPC_BRANCH): begin
        full.b         = 1'b1;
        full.is_branch = 1'b1;
        full.uses_rs1  = 1'b1;
        full.uses_rs2  = 1'b1;
        fmt            = IMM_B;
        if (f3 == 3'b010 || f3 == 3'b011)
          ill = 1'b1;
      end
      (op == OPC_JAL): begin
        full.j         = 1'b1;
        full.is_jal    = 1'b1;
        full.writes_rd = 1'b1;
        fmt            = IMM_J;
      end
      (op == OPC_JALR): begin
        full.i         = 1'b1;
        full.is_jalr   = 1'b1;
        full.uses_rs1  = 1'b1;
        full.writes_rd = 1'b1;
        fmt            = IMM_I;
        if (f3 != 3'b000)
          ill = 1'b1;
      end
      (op == OPC_LUI): begin
        full.u         = 1'b1;
        full.is_lui    = 1'b1;
        full.writes_rd = 1'b1;
        fmt            = IMM_U;
      end
      (op == OPC_AUIPC): begin
        full.u         = 1'b1;
        full.is_auipc  = 1'b1;
        full.writes_rd = 1'b1;
        fmt            = IMM_U;
      end
      (op == OPC_FENCE): begin
        full.i = 1'b1;
        fmt    = IMM_I;
      end
      (op == OPC_SYSTEM): begin
        full.i         = 1'b1;
        full.is_system = 1'b1;
        fmt            = IMM_I;
      end
      default: ill = 1'b1;
    endcase
    if (instr[1:0] != 2'b11 || instr == 32'h0 || instr == 32'hFFFF_FFFF)
      ill = 1'b1;
    if (base.rd == 5'd0)
      full.writes_rd = 1'b0;
  end

  // All formats carry their sign in instr[31]; build a signed 32-bit
  // value and let the casts sign-extend to the target width.
  always_comb begin
    imm32 = '0;
    unique case (fmt)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'h000};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                      instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_x = XLEN'(imm32);

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    if (en) begin
      illegal = ill;
      if (ill) begin
        dec = base;
      end else begin
        dec     = full;
        dec.imm = RV_XLEN'(imm_x);
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered multi-lane RV32I decode stage with a 2-entry skid buffer.
// Ports: fetch side in_*, issue side out_*, flush, clk, rst_n.
import risc_pkg::*;

module decode_stage #(
  parameter int NUM_LANES = 2,
  parameter int XLEN      = 32,
  parameter int SKID      = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [32*NUM_LANES-1:0]                in_instr,
  input  logic [XLEN-1:0]                        in_pc,
  input  logic [NUM_LANES-1:0]                   in_lane_en,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NUM_LANES*$bits(dec_lane_t)-1:0] out_dec,
  output logic [XLEN*NUM_LANES-1:0]              out_pc,
  output logic [NUM_LANES-1:0]                   out_lane_en,
  output logic [NUM_LANES-1:0]                   out_illegal
);

  // With SKID=0 only entry 0 is ever used.
  localparam logic PTR_STEP = (SKID != 0);

  dec_lane_t [NUM_LANES-1:0] dec_c;
  logic [NUM_LANES-1:0]      ill_c;

  dec_lane_t [NUM_LANES-1:0] dec_q [2];
  logic [XLEN-1:0]           pc_q  [2];
  logic [NUM_LANES-1:0]      en_q  [2];
  logic [NUM_LANES-1:0]      ill_q [2];

  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    decode_lane #(.XLEN(XLEN)) u_lane (
      .instr   (in_instr[32*g +: 32]),
      .en      (in_lane_en[g]),
      .dec     (dec_c[g]),
      .illegal (ill_c[g])
    );
  end

  assign out_valid = (count != 2'd0);

  if (SKID != 0) begin : g_skid
    assign in_ready = ~count[1];
  end else begin : g_half
    assign in_ready = (count == 2'd0) || out_ready;
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        dec_q[e] <= '0;
        pc_q[e]  <= '0;
        en_q[e]  <= '0;
        ill_q[e] <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        dec_q[wr_ptr] <= dec_c;
        pc_q[wr_ptr]  <= in_pc;
        en_q[wr_ptr]  <= in_lane_en;
        ill_q[wr_ptr] <= ill_c;
        wr_ptr        <= wr_ptr ^ PTR_STEP;
      end
      if (pop)
        rd_ptr <= rd_ptr ^ PTR_STEP;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Outputs read zero whenever the buffer is empty.
  always_comb begin
    out_dec     = '0;
    out_pc      = '0;
    out_lane_en = '0;
    out_illegal = '0;
    if (out_valid) begin
      out_dec     = dec_q[rd_ptr];
      out_lane_en = en_q[rd_ptr];
      out_illegal = ill_q[rd_ptr];
      for (int l = 0; l < NUM_LANES; l++)
        out_pc[XLEN*l +: XLEN] = pc_q[rd_ptr] + XLEN'(4 * l);
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vectors plus
// back-pressure, flush and mid-operation reset sequences.
import risc_pkg::*;

module tb_decode_stage;

  localparam int NL = 2;
  localparam int DW = $bits(dec_lane_t);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [32*NL-1:0]  in_instr;
  logic [31:0]       in_pc;
  logic [NL-1:0]     in_lane_en;
  logic              out_valid;
  logic              out_ready;
  logic [NL*DW-1:0]  out_dec;
  logic [32*NL-1:0]  out_pc;
  logic [NL-1:0]     out_lane_en;
  logic [NL-1:0]     out_illegal;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];

  decode_stage #(.NUM_LANES(NL), .XLEN(32), .SKID(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_lane_en  (in_lane_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_dec     (out_dec),
    .out_pc      (out_pc),
    .out_lane_en (out_lane_en),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic [5:0]  typ;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wr;
    logic        rs2;
  } vec_t;

  vec_t vt [20];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic dec_lane_t lane(int l);
    return out_dec[l*DW +: DW];
  endfunction

  function automatic logic [5:0] typ_of(dec_lane_t d);
    return {d.r, d.i, d.s, d.b, d.u, d.j};
  endfunction

  // One clock with a FIFO reference model of the skid buffer.
  task automatic step();
    logic pf, qf;
    logic [31:0] opc, ipc;
    pf  = in_valid && in_ready;
    qf  = out_valid && out_ready;
    opc = out_pc[31:0];
    ipc = in_pc;
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (qf) begin
      chk("pop_has_entry", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0)
        chk("order_pc", 64'(opc), 64'(q.pop_front()));
    end
    @(posedge clk);
    #1;
    if (flush)
      q.delete();
    else if (pf)
      q.push_back(ipc);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    dec_lane_t d0, d1;
    vt[0]  = '{32'hFFF00093, 1'b0, 6'b010000, 32'hFFFFFFFF, 5'd1,  1'b1, 1'b0};
    vt[1]  = '{32'hFE000EE3, 1'b0, 6'b000100, 32'hFFFFFFFC, 5'd29, 1'b0, 1'b1};
    vt[2]  = '{32'h40001033, 1'b1, 6'b000000, 32'h0,        5'd0,  1'b0, 1'b0};
    vt[3]  = '{32'h40105093, 1'b0, 6'b010000, 32'h00000401, 5'd1,  1'b1, 1'b0};
    vt[4]  = '{32'h00000000, 1'b1, 6'b000000, 32'h0,        5'd0,  1'b0, 1'b0};
    vt[5]  = '{32'hFFFFFFFF, 1'b1, 6'b000000, 32'h0,        5'd31, 1'b0, 1'b0};
    vt[6]  = '{32'h123452B7, 1'b0, 6'b000010, 32'h12345000, 5'd5,  1'b1, 1'b0};
    vt[7]  = '{32'hFF9FF0EF, 1'b0, 6'b000001, 32'hFFFFFFF8, 5'd1,  1'b1, 1'b0};
    vt[8]  = '{32'h0020A423, 1'b0, 6'b001000, 32'h00000008, 5'd8,  1'b0, 1'b1};
    vt[9]  = '{32'h00009067, 1'b1, 6'b000000, 32'h0,        5'd0,  1'b0, 1'b0};
    vt[10] = '{32'h00013083, 1'b1, 6'b000000, 32'h0,        5'd1,  1'b0, 1'b0};
    vt[11] = '{32'h00002063, 1'b1, 6'b000000, 32'h0,        5'd0,  1'b0, 1'b0};
    vt[12] = '{32'h002081B3, 1'b0, 6'b100000, 32'h0,        5'd3,  1'b1, 1'b1};
    vt[13] = '{32'h00000013, 1'b0, 6'b010000, 32'h0,        5'd0,  1'b0, 1'b0};
    vt[14] = '{32'h0000007B, 1'b1, 6'b000000, 32'h0,        5'd0,  1'b0, 1'b0};
    vt[15] = '{32'h00000001, 1'b1, 6'b000000, 32'h0,        5'd0,  1'b0, 1'b0};
    vt[16] = '{32'h40208133, 1'b0, 6'b100000, 32'h0,        5'd2,  1'b1, 1'b1};
    vt[17] = '{32'h40109093, 1'b1, 6'b000000, 32'h0,        5'd1,  1'b0, 1'b0};
    vt[18] = '{32'h80000097, 1'b0, 6'b000010, 32'h80000000, 5'd1,  1'b1, 1'b0};
    vt[19] = '{32'h00000073, 1'b0, 6'b010000, 32'h0,        5'd0,  1'b0, 1'b0};

    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_instr   = '0;
    in_pc      = '0;
    in_lane_en = '0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_dec", 64'(|out_dec), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_lane_en", 64'(out_lane_en), 64'd0);
    chk("rst_illegal", 64'(out_illegal), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-lane decode table; lane 1 carries junk but is disabled.
    for (int k = 0; k < 20; k++) begin
      in_valid   = 1'b1;
      in_instr   = {32'hFFFF_FFFF, vt[k].instr};
      in_lane_en = 2'b01;
      in_pc      = 32'h200 + 32'(k * 8);
      step();
      in_valid = 1'b0;
      d0 = lane(0);
      d1 = lane(1);
      chk($sformatf("v%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_ill", k), 64'(out_illegal[0]), 64'(vt[k].ill));
      chk($sformatf("v%0d_typ", k), 64'(typ_of(d0)), 64'(vt[k].typ));
      chk($sformatf("v%0d_imm", k), 64'(d0.imm), 64'(vt[k].imm));
      chk($sformatf("v%0d_rd", k), 64'(d0.rd), 64'(vt[k].rd));
      chk($sformatf("v%0d_wr", k), 64'(d0.writes_rd), 64'(vt[k].wr));
      chk($sformatf("v%0d_rs2", k), 64'(d0.uses_rs2), 64'(vt[k].rs2));
      chk($sformatf("v%0d_l1_zero", k), 64'(|d1), 64'd0);
      chk($sformatf("v%0d_l1_ill", k), 64'(out_illegal[1]), 64'd0);
      chk($sformatf("v%0d_lane_en", k), 64'(out_lane_en), 64'd1);
      step();
    end

    // Two lanes: zero word is illegal, BEQ -4; lane PCs.
    in_valid   = 1'b1;
    in_instr   = {32'h0000_0000, 32'hFE000EE3};
    in_lane_en = 2'b11;
    in_pc      = 32'h100;
    step();
    in_valid = 1'b0;
    d0 = lane(0);
    d1 = lane(1);
    chk("two_illegal", 64'(out_illegal), 64'd2);
    chk("two_l1_typ", 64'(typ_of(d1)), 64'd0);
    chk("two_l1_imm", 64'(d1.imm), 64'd0);
    chk("two_l0_branch", 64'(d0.is_branch), 64'd1);
    chk("two_l0_imm", 64'(d0.imm), 64'hFFFFFFFC);
    chk("two_pc0", 64'(out_pc[31:0]), 64'h100);
    chk("two_pc1", 64'(out_pc[63:32]), 64'h104);
    chk("two_lane_en", 64'(out_lane_en), 64'd3);
    step();

    // PC wrap on lane 1.
    in_valid = 1'b1;
    in_instr = {32'hFFF00093, 32'hFFF00093};
    in_pc    = 32'hFFFF_FFFC;
    step();
    in_valid = 1'b0;
    chk("wrap_pc1", 64'(out_pc[63:32]), 64'h0);
    chk("wrap_illegal", 64'(out_illegal), 64'd0);
    step();

    // Back-pressure: three back-to-back pushes, only two fit.
    in_lane_en = 2'b01;
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_pc      = 32'h1000;
    step();
    in_pc = 32'h2000;
    step();
    in_pc = 32'h3000;
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    step();
    step();
    chk("bp_hold_pc", 64'(out_pc[31:0]), 64'h1000);
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    chk("bp_third_pc", 64'(out_pc[31:0]), 64'h3000);
    step();
    chk("bp_drained", 64'(q.size()), 64'd0);
    step();

    // Flush at count==2 with a bundle offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h4000;
    step();
    in_pc = 32'h5000;
    step();
    in_pc = 32'h6000;
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    // Flush drops an accepted push in the same cycle.
    in_valid = 1'b1;
    in_pc    = 32'h7000;
    step();
    in_pc = 32'h8000;
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl2_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) step();
    in_valid = 1'b1;
    in_pc    = 32'h9000;
    step();
    in_valid = 1'b0;
    chk("fl_next_pc", 64'(out_pc[31:0]), 64'h9000);
    step();

    // Reset pulse while a bundle is stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'hA000;
    step();
    in_valid = 1'b0;
    chk("mr_before", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_out_dec", 64'(|out_dec), 64'd0);
    chk("mr_out_pc", 64'(out_pc), 64'd0);
    chk("mr_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    out_ready = 1'b1;
    repeat (3) step();
    chk("mr_after", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
